// File: rtl/des_key_schedule.sv
`default_nettype none
// ============================================================================
// Module      : round_key_gen
// Description : One DES key-schedule round. Rotates both 28-bit halves of the
//               56-bit CD register left by 1 (shift=1) or 2 (shift=0) and
//               compresses the rotated value through PC-2 into a 48-bit subkey.
// Ports       : din       [0:55] current CD value (bit 0 = MSB)
//               shift            1 = rotate by one, 0 = rotate by two
//               next_key  [0:55] rotated CD, fed back into the CD register
//               round_key [0:47] PC-2 of the rotated CD
// Revision    : 1.0  initial release
// ============================================================================
module round_key_gen (
    input  logic [0:55] din,
    input  logic        shift,
    output logic [0:55] next_key,
    output logic [0:47] round_key
);

    // PC-2, 1-based source positions into CD, first output bit first.
    localparam logic [8*48-1:0] C_PC2_TBL = {
        8'd14, 8'd17, 8'd11, 8'd24, 8'd1,  8'd5,
        8'd3,  8'd28, 8'd15, 8'd6,  8'd21, 8'd10,
        8'd23, 8'd19, 8'd12, 8'd4,  8'd26, 8'd8,
        8'd16, 8'd7,  8'd27, 8'd20, 8'd13, 8'd2,
        8'd41, 8'd52, 8'd31, 8'd37, 8'd47, 8'd55,
        8'd30, 8'd40, 8'd51, 8'd45, 8'd33, 8'd48,
        8'd44, 8'd49, 8'd39, 8'd56, 8'd34, 8'd53,
        8'd46, 8'd42, 8'd50, 8'd36, 8'd29, 8'd32
    };

    function automatic logic [0:47] pc2(input logic [0:55] cd);
        logic [5:0] src;
        pc2 = '0;
        for (int i = 0; i < 48; i++) begin
            src    = 6'(C_PC2_TBL[8*(47-i) +: 8] - 8'd1);
            pc2[i] = cd[src];
        end
    endfunction

    logic [0:27] w_c;
    logic [0:27] w_d;

    // Independent left rotation of the C and D halves.
    assign w_c = shift ? {din[1:27],  din[0]}     : {din[2:27],  din[0:1]};
    assign w_d = shift ? {din[29:55], din[28]}    : {din[30:55], din[28:29]};

    assign next_key  = {w_c, w_d};
    assign round_key = pc2(next_key);

endmodule

// ============================================================================
// Module      : des_key_schedule
// Description : DES key-schedule controller. Loads a 64-bit key through PC-1,
//               runs sixteen round_key_gen iterations to fill a 16x48 subkey
//               store, then streams the subkeys one per cycle in encrypt
//               (K1..K16) or decrypt (K16..K1) order.
// Ports       : clk              rising-edge clock
//               rst_n            asynchronous active-low reset
//               key_load         one-cycle request to load and expand key_in
//               key_in    [0:63] DES key, bit 0 = MSB, parity bits ignored
//               rk_req           one-cycle request to stream the schedule
//               decrypt          order select, sampled with rk_req
//               key_busy         expanding or streaming
//               keys_ready       store holds a complete schedule
//               rk_valid         round_key valid this cycle
//               round_key [0:47] current subkey (registered)
//               rk_last          marks the 16th beat of a stream
// Revision    : 1.0  initial release
// ============================================================================
module des_key_schedule (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_load,
    input  logic [0:63] key_in,
    input  logic        rk_req,
    input  logic        decrypt,
    output logic        key_busy,
    output logic        keys_ready,
    output logic        rk_valid,
    output logic [0:47] round_key,
    output logic        rk_last
);

    localparam logic [1:0] C_ST_IDLE   = 2'd0;
    localparam logic [1:0] C_ST_EXPAND = 2'd1;
    localparam logic [1:0] C_ST_READY  = 2'd2;
    localparam logic [1:0] C_ST_STREAM = 2'd3;

    // PC-1, 1-based source positions into the key; parity bits never appear.
    localparam logic [8*56-1:0] C_PC1_TBL = {
        8'd57, 8'd49, 8'd41, 8'd33, 8'd25, 8'd17, 8'd9,
        8'd1,  8'd58, 8'd50, 8'd42, 8'd34, 8'd26, 8'd18,
        8'd10, 8'd2,  8'd59, 8'd51, 8'd43, 8'd35, 8'd27,
        8'd19, 8'd11, 8'd3,  8'd60, 8'd52, 8'd44, 8'd36,
        8'd63, 8'd55, 8'd47, 8'd39, 8'd31, 8'd23, 8'd15,
        8'd7,  8'd62, 8'd54, 8'd46, 8'd38, 8'd30, 8'd22,
        8'd14, 8'd6,  8'd61, 8'd53, 8'd45, 8'd37, 8'd29,
        8'd21, 8'd13, 8'd5,  8'd28, 8'd20, 8'd12, 8'd4
    };

    function automatic logic [0:55] pc1(input logic [0:63] k);
        logic [5:0] src;
        pc1 = '0;
        for (int i = 0; i < 56; i++) begin
            src    = 6'(C_PC1_TBL[8*(55-i) +: 8] - 8'd1);
            pc1[i] = k[src];
        end
    endfunction

    logic [1:0]  r_state;
    logic [0:55] r_cd;
    logic [3:0]  r_cnt;
    logic        r_dir;
    logic        r_keys_ready;
    logic        r_rk_valid;
    logic        r_rk_last;
    logic [0:47] r_round_key;
    logic [0:47] r_store [0:15];

    logic        w_shift;
    logic [0:55] w_next_cd;
    logic [0:47] w_subkey;
    logic [3:0]  w_rd_idx;

    // Single-bit rotations happen in rounds 1, 2, 9 and 16.
    assign w_shift = (r_cnt == 4'd0) || (r_cnt == 4'd1) ||
                     (r_cnt == 4'd8) || (r_cnt == 4'd15);

    assign w_rd_idx = r_dir ? (4'd15 - r_cnt) : r_cnt;

    round_key_gen u_round_key_gen (
        .din       (r_cd),
        .shift     (w_shift),
        .next_key  (w_next_cd),
        .round_key (w_subkey)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= C_ST_IDLE;
            r_cd         <= '0;
            r_cnt        <= '0;
            r_dir        <= 1'b0;
            r_keys_ready <= 1'b0;
            r_rk_valid   <= 1'b0;
            r_rk_last    <= 1'b0;
            r_round_key  <= '0;
        end else begin
            r_rk_valid <= 1'b0;
            r_rk_last  <= 1'b0;
            case (r_state)
                C_ST_IDLE: begin
                    if (key_load) begin
                        r_cd         <= pc1(key_in);
                        r_cnt        <= '0;
                        r_keys_ready <= 1'b0;
                        r_state      <= C_ST_EXPAND;
                    end
                end
                C_ST_EXPAND: begin
                    // cnt rolls 15 -> 0 exactly as the state exits.
                    r_cd  <= w_next_cd;
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'd15) begin
                        r_keys_ready <= 1'b1;
                        r_state      <= C_ST_READY;
                    end
                end
                C_ST_READY: begin
                    // A new key takes priority over a stream request.
                    if (key_load) begin
                        r_cd         <= pc1(key_in);
                        r_cnt        <= '0;
                        r_keys_ready <= 1'b0;
                        r_state      <= C_ST_EXPAND;
                    end else if (rk_req) begin
                        r_dir   <= decrypt;
                        r_cnt   <= '0;
                        r_state <= C_ST_STREAM;
                    end
                end
                C_ST_STREAM: begin
                    r_rk_valid  <= 1'b1;
                    r_round_key <= r_store[w_rd_idx];
                    r_rk_last   <= (r_cnt == 4'd15);
                    r_cnt       <= r_cnt + 4'd1;
                    if (r_cnt == 4'd15) begin
                        r_state <= C_ST_READY;
                    end
                end
                default: begin
                    r_state <= C_ST_IDLE;
                end
            endcase
        end
    end

    // Subkey store is not reset; its contents only matter once keys_ready is set.
    always_ff @(posedge clk) begin
        if (r_state == C_ST_EXPAND) begin
            r_store[r_cnt] <= w_subkey;
        end
    end

    assign key_busy   = (r_state == C_ST_EXPAND) || (r_state == C_ST_STREAM);
    assign keys_ready = r_keys_ready;
    assign rk_valid   = r_rk_valid;
    assign rk_last    = r_rk_last;
    assign round_key  = r_round_key;

endmodule
`default_nettype wire
